// File: rtl/udp_filter_drain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// udp_filter_drain_ctrl : drains committed udp_filter frames onto AXI-Stream
// Revision: 1.0
// ---------------------------------------------------------------------------
module udp_filter_drain_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 11,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  s_rst_n_i,
  input  logic                  en_i,
  input  logic                  frame_valid_i,
  input  logic                  fifo_wr_en_i,
  input  logic                  fifo_rst_n_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] wr_cnt;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] rd_cnt;
  logic                 fifo_rst_n_q;
  logic                 commit;
  logic                 drop_edge;
  logic                 wr_overflow;

  // Write-low term separates the FIFO_FINISH phase from payload writes.
  assign commit      = (state == IDLE) && frame_valid_i && !fifo_wr_en_i && en_i;
  assign drop_edge   = !fifo_rst_n_i && fifo_rst_n_q;
  assign wr_overflow = fifo_wr_en_i && fifo_rst_n_i && (wr_cnt == LEN_MAX);

  always_comb begin
    state_nxt       = state;
    fifo_rd_en_o    = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tdata_o  = fifo_data_i;
    busy_o          = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = (wr_cnt == '0) ? RELEASE : DRAIN;
        end
      end
      DRAIN: begin
        busy_o          = 1'b1;
        m_axis_tvalid_o = !fifo_empty_i;
        m_axis_tlast_o  = m_axis_tvalid_o && (rd_cnt == len - LEN_ONE);
        fifo_rd_en_o    = m_axis_tvalid_o && m_axis_tready_i;
        if (fifo_rd_en_o && m_axis_tlast_o) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        busy_o = 1'b1;
        if (!frame_valid_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      len          <= '0;
      rd_cnt       <= '0;
      fifo_rst_n_q <= 1'b1;
      frame_cnt_o  <= '0;
      drop_cnt_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      fifo_rst_n_q <= fifo_rst_n_i;

      // A dropped frame wins over any same-cycle write.
      if (!fifo_rst_n_i) begin
        wr_cnt <= '0;
      end else if (commit) begin
        wr_cnt <= '0;
      end else if (fifo_wr_en_i && (wr_cnt != LEN_MAX)) begin
        wr_cnt <= wr_cnt + LEN_ONE;
      end

      if (drop_edge) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end

      if (commit) begin
        len    <= wr_cnt;
        rd_cnt <= '0;
      end else if (fifo_rd_en_o) begin
        rd_cnt <= rd_cnt + LEN_ONE;
      end

      if (fifo_rd_en_o && m_axis_tlast_o) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end

      if (wr_overflow || ((state == DRAIN) && fifo_wr_en_i) || (commit && (wr_cnt == '0))) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_filter_drain_ctrl.sv
`default_nettype none
// tb_udp_filter_drain_ctrl : directed + randomized frames through a queue FIFO model,
// beats checked by a scoreboard monitor against the per-frame expected word list.
module tb_udp_filter_drain_ctrl;
  localparam int DW = 64;
  localparam int LW = 11;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_rst_n     = 1'b0;
  logic          en          = 1'b1;
  logic          frame_valid = 1'b0;
  logic          fifo_wr_en  = 1'b0;
  logic          fifo_rst_n  = 1'b1;
  logic [DW-1:0] wr_data     = '0;
  logic [DW-1:0] fifo_data   = '0;
  logic          fifo_empty  = 1'b1;
  logic          tready      = 1'b1;
  logic          fifo_rd_en, tvalid, tlast, busy, err;
  logic [DW-1:0] tdata;
  logic [CW-1:0] frame_cnt, drop_cnt;

  udp_filter_drain_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .s_rst_n_i(s_rst_n), .en_i(en), .frame_valid_i(frame_valid),
    .fifo_wr_en_i(fifo_wr_en), .fifo_rst_n_i(fifo_rst_n), .fifo_data_i(fifo_data),
    .fifo_empty_i(fifo_empty), .fifo_rd_en_o(fifo_rd_en), .m_axis_tdata_o(tdata),
    .m_axis_tvalid_o(tvalid), .m_axis_tlast_o(tlast), .m_axis_tready_i(tready),
    .busy_o(busy), .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt), .err_o(err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] cur[$];
  int vectors = 0, miscompares = 0;
  int exp_frames = 0, exp_drops = 0;
  logic exp_err = 1'b0;
  int ready_mode = 0, cyc = 0, drain_cycles = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Signals sampled mid-cycle, applied to the FIFO model just after the next edge.
  logic s_wr = 1'b0, s_rd = 1'b0, s_frst = 1'b1, s_rst = 1'b0;
  logic [DW-1:0] s_wdata = '0;
  logic prev_stall = 1'b0;
  beat_t prev_b;

  always @(negedge clk) begin
    beat_t b;
    s_wr = fifo_wr_en; s_wdata = wr_data; s_rd = fifo_rd_en; s_frst = fifo_rst_n; s_rst = s_rst_n;
    if (s_rst_n) begin
      chk("rd_en_vs_handshake", {63'd0, fifo_rd_en}, {63'd0, tvalid & tready});
      if (prev_stall) begin
        chk("axis_hold_valid", {63'd0, tvalid}, 64'd1);
        chk("axis_hold_data", tdata, prev_b.data);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got data %0h last %0b expected no beat", tdata, tlast);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", tdata, b.data);
          chk("beat_last", {63'd0, tlast}, {63'd0, b.last});
        end
      end
      prev_stall = tvalid && !tready;
      prev_b.data = tdata;
      prev_b.last = tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!s_rst || !s_frst) begin
      fifo_q.delete();
    end else begin
      if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (s_wr) fifo_q.push_back(s_wdata);
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
    cyc++;
    case (ready_mode)
      1:       tready = (cyc % 3 == 0);
      2:       tready = 1'($urandom % 2);
      default: tready = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_words(int n);
    cur.delete();
    for (int i = 0; i < n; i++) begin
      frame_valid = 1'b1; fifo_wr_en = 1'b1;
      wr_data = {$urandom, $urandom};
      cur.push_back(wr_data);
      step();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic expect_frame();
    beat_t b;
    for (int i = 0; i < cur.size(); i++) begin
      b.data = cur[i];
      b.last = (i == cur.size() - 1);
      exp_q.push_back(b);
    end
    exp_frames++;
  endtask

  task automatic wait_drained();
    drain_cycles = 0;
    do begin
      step(); drain_cycles++;
    end while (exp_q.size() != 0 && drain_cycles < 500);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic commit_and_drain();
    expect_frame();
    frame_valid = 1'b1; fifo_wr_en = 1'b0;
    wait_drained();
    frame_valid = 1'b0;
    step(); step();
  endtask

  task automatic check_counters(string tag);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drops));
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
  endtask

  task automatic drop_frame(int nwr, int low_cycles);
    write_words(nwr);
    frame_valid = 1'b0; fifo_rst_n = 1'b0;
    repeat (low_cycles) step();
    fifo_rst_n = 1'b1;
    exp_drops++;
    cur.delete();
    step(); step();
  endtask

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("reset_tvalid", {63'd0, tvalid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    step();
    check_counters("reset");

    // Good 8-word frame, continuous ready: beats on consecutive cycles, 1-cycle latency.
    write_words(8);
    commit_and_drain();
    chk("t1_drain_cycles", 64'(drain_cycles), 64'd9);
    check_counters("t1");

    // Dropped frame followed by a 5-word good frame.
    drop_frame(3, 1);
    check_counters("t2_drop");
    write_words(5);
    commit_and_drain();
    check_counters("t2");

    // Backpressure pattern.
    ready_mode = 1;
    write_words(6);
    commit_and_drain();
    ready_mode = 0;
    check_counters("t3");

    // Enable held low across the commit condition.
    write_words(4);
    expect_frame();
    en = 1'b0; frame_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_tvalid", {63'd0, tvalid}, 64'd0);
      chk("t4_hold_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    @(negedge clk);
    chk("t4_commit_cycle_tvalid", {63'd0, tvalid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_first_tvalid", {63'd0, tvalid}, 64'd1);
    @(posedge clk); #1;
    wait_drained();
    frame_valid = 1'b0;
    step(); step();
    check_counters("t4");

    // Back-to-back frames: RELEASE holds while frame_valid stays high.
    write_words(4);
    expect_frame();
    frame_valid = 1'b1;
    wait_drained();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_release_busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    frame_valid = 1'b0;
    step(); step();
    write_words(2);
    commit_and_drain();
    check_counters("t5");

    // Commit with nothing written.
    frame_valid = 1'b1;
    step(); step();
    exp_err = 1'b1;
    @(negedge clk);
    chk("t6_empty_commit_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    step(); step();
    check_counters("t6_err");

    // Reset after 2 of 5 beats.
    write_words(5);
    expect_frame();
    frame_valid = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() > 3 && n < 100) begin step(); n++; end
    end
    s_rst_n = 1'b0; frame_valid = 1'b0;
    exp_q.delete();
    exp_frames = 0; exp_drops = 0; exp_err = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("t6_rst_tlast", {63'd0, tlast}, 64'd0);
    chk("t6_rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_counters("t6_rst");
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    step();

    // Randomized frames with random drops and ready patterns.
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) == 0) drop_frame($urandom_range(1, 3), $urandom_range(1, 3));
      ready_mode = $urandom_range(0, 2);
      write_words($urandom_range(1, 12));
      commit_and_drain();
      ready_mode = 0;
    end
    check_counters("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/udp_filter_drain_ctrl.md
Name: udp_filter_drain_ctrl

Overview:
Read-side controller for the frame FIFO that udp_filter writes.
- Tracks how many words the filter has written for the current frame.
- Clears that count when the filter drops a frame (FIFO reset).
- Once the filter declares the frame valid and finished, drains the FIFO onto an AXI-Stream master with correct tlast.
- Keeps accept/drop statistics.
- Sits between udp_filter/FIFO and the downstream AXIS consumer, in the same clock domain.

Parameters:
DATA_WIDTH, 64, FIFO word and tdata width
LEN_WIDTH, 11, frame length counter width in words (max frame 2^LEN_WIDTH-1 words)
CNT_WIDTH, 32, statistics counter width

Ports:
clk_i  in  1  clock
s_rst_n_i  in  1  synchronous active-low reset
en_i  in  1  permits starting a new drain
frame_valid_i  in  1  filter frame_valid_o
fifo_wr_en_i  in  1  mirror of filter fifo_wr_en_o
fifo_rst_n_i  in  1  mirror of filter fifo_rst_n_o (low = frame dropped)
fifo_data_i  in  DATA_WIDTH  FIFO read data, first-word-fall-through
fifo_empty_i  in  1  FIFO empty
fifo_rd_en_o  out  1  FIFO pop
m_axis_tdata_o  out  DATA_WIDTH  stream data
m_axis_tvalid_o  out  1  stream valid
m_axis_tlast_o  out  1  last word of frame
m_axis_tready_i  in  1  stream ready
busy_o  out  1  high in DRAIN or RELEASE
frame_cnt_o  out  CNT_WIDTH  frames fully drained, wraps
drop_cnt_o  out  CNT_WIDTH  frames dropped by filter, wraps
err_o  out  1  sticky protocol error, cleared only by reset

Behaviour:
Clock and reset:
- One clock, clk_i.
- Reset is synchronous and active-low on s_rst_n_i.
- Reset values: state IDLE, wr_cnt 0, len 0, rd_cnt 0, all counters 0, err_o 0.
- Reset values for combinational outputs: fifo_rd_en_o 0, m_axis_tvalid_o 0, m_axis_tlast_o 0, busy_o 0.
- m_axis_tdata_o is don't-care while tvalid is 0.
- Reset mid-drain abandons the frame immediately; FIFO contents are not this block's responsibility.

Write tracking (all states):
- wr_cnt increments on each fifo_wr_en_i=1, saturating at 2^LEN_WIDTH-1.
- Saturation sets err_o.
- fifo_rst_n_i=0 clears wr_cnt to 0 the next cycle and increments drop_cnt_o by 1.
  - A multi-cycle low level counts once, on the falling edge.
- fifo_rst_n_i=0 has priority over a same-cycle write.
- fifo_wr_en_i=1 while in DRAIN sets err_o; the write is still counted into wr_cnt.

State IDLE:
- Commit condition: frame_valid_i=1 and fifo_wr_en_i=0 and en_i=1. This is the filter's FIFO_FINISH phase; frame_valid_i is also high during payload writes, so the write-low term is mandatory.
- On commit: len<=wr_cnt, wr_cnt<=0, rd_cnt<=0, go to DRAIN.
- If the commit condition holds with wr_cnt=0: set err_o, go to RELEASE.
- With en_i=0, stay in IDLE; the filter holds in FIFO_FINISH.

State DRAIN:
- m_axis_tvalid_o = !fifo_empty_i.
- m_axis_tdata_o = fifo_data_i.
- fifo_rd_en_o = tvalid & m_axis_tready_i; never pop an empty FIFO.
- m_axis_tlast_o = tvalid & (rd_cnt == len-1).
- rd_cnt increments on each pop.
- Pop with tlast: frame_cnt_o+1, go to RELEASE.
- tvalid may drop mid-frame if the FIFO underruns; tdata is held by the FIFO.
- Once asserted, tvalid with data stays stable until tready (AXIS rule).

State RELEASE:
- Wait for frame_valid_i=0 (filter returned to IDLE), then go to IDLE.
- Prevents a double commit.
- Write tracking remains active here.

Pipelining and latency:
- All outputs in DRAIN are combinational from state, FIFO and tready.
- Throughput is one word per cycle under continuous tready.
- Latency from commit cycle to first tvalid is 1 cycle.

Test Plan:
1. Good frame, 8 words written, then frame_valid_i=1 with wr_en=0, tready=1 -> 8 beats on consecutive cycles, tlast on beat 8 only; frame_cnt_o=1, drop_cnt_o=0.
2. Filter drops a frame: 3 writes, then fifo_rst_n_i low for 1 cycle -> wr_cnt=0, drop_cnt_o=1, no tvalid. A following 5-word good frame drains exactly 5 beats with tlast on beat 5.
3. Backpressure: 6-word frame, tready toggled 1,0,0,1,... -> tdata/tvalid held stable while tready=0, no pop while stalled, exactly 6 pops, tlast on 6th.
4. en_i=0 during commit condition for 10 cycles, then 1 -> no tvalid until the cycle after en_i rises; frame then drains normally.
5. Back-to-back frames (4 words, then 2 words) -> RELEASE waits until frame_valid_i falls; second frame counted from its own writes only; frame_cnt_o=2.
6. Errors: commit with wr_cnt=0 -> err_o=1, no beats. Separately, reset asserted mid-drain after 2 of 5 beats -> all outputs at reset values next cycle, counters 0.
